mole_game_core: RTL and testbench



---
 rtl/mole_game_core.sv | 101 ++++++++++
 tb/tb_mole_game_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mole_game_core.sv
// mole_game_core: N-target whack-a-mole core with lives, edge-detected buttons, timers and difficulty scaling.
module mole_game_core #(
  parameter int N_TARGETS  = 7,
  parameter int SCORE_W    = 8,
  parameter int TIMER_W    = 16,
  parameter int GAME_TICKS = 60000,
  parameter int ROUND_BASE = 5000,
  parameter int ROUND_STEP = 1000,
  parameter int ROUND_MIN  = 2000,
  parameter int LEVEL_STEP = 5,
  parameter int MAX_LIT    = 4,
  parameter int LIVES      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_TARGETS-1:0] btn,
  output logic [N_TARGETS-1:0] targets,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           lives_left,
  output logic [3:0]           level,
  output logic                 busy,
  output logic                 game_over,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);
  typedef enum logic [1:0] {IDLE, LOAD, SHOW, OVER} state_t;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [N_TARGETS-1:0] btn_q, hit_mask, press, mask_n, pattern;
  logic [TIMER_W-1:0] game_t, round_t, round_preset;
  logic [31:0] lvl_full, lit_full, num_lit, red, cnt;
  logic wrong, done, hit, miss, game_end, go;
  always_comb begin
    lvl_full = 32'(score) / 32'(LEVEL_STEP);
    level = lvl_full > 32'd15 ? 4'd15 : lvl_full[3:0];
    lit_full = 32'(level) + 32'd1;
    num_lit = lit_full > 32'(MAX_LIT) ? 32'(MAX_LIT) : lit_full;
    red = 32'(level) * 32'(ROUND_STEP);
    round_preset = TIMER_W'(32'(ROUND_BASE) >= red + 32'(ROUND_MIN) ? 32'(ROUND_BASE) - red : 32'(ROUND_MIN));
  end
  // random bits first, then pad from the LSB so exactly num_lit targets light
  always_comb begin
    pattern = '0;
    cnt = '0;
    for (int i = 0; i < N_TARGETS; i++)
      if (lfsr[i%16] && cnt < num_lit) begin
        pattern[i] = 1'b1;
        cnt = cnt + 32'd1;
      end
    for (int i = 0; i < N_TARGETS; i++)
      if (!pattern[i] && cnt < num_lit) begin
        pattern[i] = 1'b1;
        cnt = cnt + 32'd1;
      end
  end
  always_comb begin
    press = btn & ~btn_q;
    mask_n = hit_mask | (press & targets);
    wrong = |(press & ~targets);
    done = mask_n == targets;
    go = start && (state == IDLE || state == OVER);
    hit = state == SHOW && !wrong && done;
    miss = state == SHOW && (wrong || (!done && round_t == '0));
    game_end = (state == LOAD || state == SHOW) && game_t == '0;
    state_n = go ? LOAD
            : (game_end || (miss && lives_left <= 4'd1)) ? OVER
            : (hit || miss) ? LOAD
            : state == LOAD ? SHOW
            : state;
    busy = state == LOAD || state == SHOW;
    game_over = state == OVER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      targets <= '0;
      score <= '0;
      lives_left <= 4'(LIVES);
      lfsr <= 16'hACE1;
      btn_q <= '0;
      hit_mask <= '0;
      game_t <= '0;
      round_t <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state <= state_n;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      btn_q <= btn;
      hit_pulse <= hit;
      miss_pulse <= miss;
      targets <= (state_n == OVER || go) ? '0 : state == LOAD ? pattern : targets;
      hit_mask <= state == SHOW ? mask_n : '0;
      round_t <= state == LOAD ? round_preset : round_t - TIMER_W'(state == SHOW && round_t != '0);
      game_t <= go ? TIMER_W'(GAME_TICKS) : game_t - TIMER_W'(state == SHOW && game_t != '0);
      score <= go ? '0 : (hit && score != '1) ? score + 1'b1 : score;
      lives_left <= go ? 4'(LIVES) : (miss && lives_left != 4'd0) ? lives_left - 4'd1 : lives_left;
    end
  end
endmodule

// File: tb/tb_mole_game_core.sv
// tb_mole_game_core: vector table for reset/idle/start plus directed game sequences.
module tb_mole_game_core;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic [6:0] btn, btn2;
  logic [6:0] targets, targets2;
  logic [7:0] score, score2;
  logic [3:0] lives_left, lives2, level, level2;
  logic busy, busy2, game_over, over2, hit_pulse, hit2, miss_pulse, miss2;
  logic [15:0] m_lfsr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mole_game_core #(.N_TARGETS(7), .GAME_TICKS(200), .ROUND_BASE(20), .ROUND_STEP(5),
                   .ROUND_MIN(10), .LEVEL_STEP(2), .LIVES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .targets(targets), .score(score),
    .lives_left(lives_left), .level(level), .busy(busy), .game_over(game_over),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));

  mole_game_core #(.N_TARGETS(7), .GAME_TICKS(12), .ROUND_BASE(20), .ROUND_STEP(5),
                   .ROUND_MIN(10), .LEVEL_STEP(2), .LIVES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .btn(btn2), .targets(targets2), .score(score2),
    .lives_left(lives2), .level(level2), .busy(busy2), .game_over(over2),
    .hit_pulse(hit2), .miss_pulse(miss2));

  always @(posedge clk)
    m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  typedef struct {
    logic rst; logic start; logic [6:0] btn;
    logic busy; logic over; int score; int lives; int level; int pop;
  } vec_t;
  vec_t tbl[7];
  logic [15:0] snap[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int nlit(input int s);
    int l;
    l = s / 2;
    if (l > 15) l = 15;
    return (l + 1 > 4) ? 4 : l + 1;
  endfunction

  function automatic logic [6:0] pat(input logic [15:0] l, input int n);
    logic [6:0] p;
    int c;
    p = '0;
    c = 0;
    for (int i = 0; i < 7; i++) if (l[i] && c < n) begin p[i] = 1'b1; c++; end
    for (int i = 0; i < 7; i++) if (!p[i] && c < n) begin p[i] = 1'b1; c++; end
    return p;
  endfunction

  function automatic logic [6:0] lowbit(input logic [6:0] x);
    return x & (~x + 7'd1);
  endfunction

  initial begin
    logic [6:0] exp_t, lo, hi;
    int n;
    logic saw_miss;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; btn = '0; btn2 = '0;
    tbl[0] = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 0, 2, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 0, 2, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 0, 2, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 7'h7F, 1'b0, 1'b0, 0, 2, 0, 0};
    tbl[4] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 0, 2, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 0, 2, 0, -1};
    tbl[6] = '{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 0, 2, 0, 1};
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; btn = tbl[i].btn;
      tick();
      snap[i] = m_lfsr;
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_over", i), game_over, tbl[i].over);
      chk($sformatf("v%0d_score", i), score, tbl[i].score);
      chk($sformatf("v%0d_lives", i), lives_left, tbl[i].lives);
      chk($sformatf("v%0d_level", i), level, tbl[i].level);
      chk($sformatf("v%0d_hit", i), hit_pulse, 0);
      chk($sformatf("v%0d_miss", i), miss_pulse, 0);
      if (tbl[i].pop >= 0) chk($sformatf("v%0d_pop", i), $countones(targets), tbl[i].pop);
    end
    chk("first_pattern", targets, pat(snap[5], 1));
    // single-target hit, then hold the button
    btn = targets; tick();
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_score", score, 1);
    exp_t = pat(m_lfsr, nlit(1));
    tick();
    chk("hit1_pulse_len", hit_pulse, 0);
    chk("pattern2", targets, exp_t);
    repeat (3) tick();
    chk("held_score", score, 1);
    chk("held_no_pulse", hit_pulse, 0);
    btn = '0; tick();
    // level 1: two lit targets, hit across cycles
    btn = targets; tick();
    chk("hit2_score", score, 2);
    chk("hit2_level", level, 1);
    exp_t = pat(m_lfsr, nlit(2));
    btn = '0; tick();
    chk("pattern3", targets, exp_t);
    chk("pattern3_pop", $countones(targets), 2);
    lo = lowbit(targets); hi = targets & ~lo;
    btn = lo; tick();
    chk("partial_no_hit", hit_pulse, 0);
    chk("partial_score", score, 2);
    btn = '0; tick(); tick();
    btn = hi; tick();
    chk("partial_hit_pulse", hit_pulse, 1);
    chk("partial_hit_score", score, 3);
    exp_t = pat(m_lfsr, nlit(3));
    btn = '0; tick();
    chk("pattern4", targets, exp_t);
    // completing press with a wrong press in the same cycle: miss wins
    btn = targets | lowbit(~targets & 7'h7F); tick();
    chk("both_miss", miss_pulse, 1);
    chk("both_no_hit", hit_pulse, 0);
    chk("both_score", score, 3);
    chk("both_lives", lives_left, 1);
    exp_t = pat(m_lfsr, nlit(3));
    btn = '0; tick();
    chk("pattern5", targets, exp_t);
    chk("miss_pulse_len", miss_pulse, 0);
    // round timeout with preset 15 takes the last life
    n = 0;
    while (!miss_pulse && n < 40) begin tick(); n++; end
    chk("timeout_cycles", n, 16);
    chk("timeout_lives", lives_left, 0);
    chk("timeout_over", game_over, 1);
    chk("timeout_targets", targets, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_score_held", score, 3);
    // restart from OVER
    start = 1'b1; tick();
    chk("restart_score", score, 0);
    chk("restart_lives", lives_left, 2);
    chk("restart_busy", busy, 1);
    chk("restart_over", game_over, 0);
    exp_t = pat(m_lfsr, 1);
    start = 1'b0; tick();
    chk("restart_pattern", targets, exp_t);
    btn = targets; tick();
    chk("pre_rst_score", score, 1);
    btn = '0; tick();
    btn = lowbit(~targets & 7'h7F); tick();
    chk("pre_rst_lives", lives_left, 1);
    btn = '0; tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; tick();
    chk("rst_targets", targets, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives_left, 2);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    rst = 1'b0;
    // short game: the game timer expires before any round timeout
    start2 = 1'b1; tick();
    chk("g2_busy", busy2, 1);
    start2 = 1'b0; tick();
    n = 0;
    saw_miss = 1'b0;
    while (!over2 && n < 50) begin tick(); n++; saw_miss |= miss2; end
    chk("g2_over_cycles", n, 13);
    chk("g2_no_miss", saw_miss, 0);
    chk("g2_lives", lives2, 2);
    chk("g2_score", score2, 0);
    chk("g2_targets", targets2, 0);
    start2 = 1'b1; tick();
    chk("g2_restart_score", score2, 0);
    chk("g2_restart_lives", lives2, 2);
    chk("g2_restart_busy", busy2, 1);
    chk("g2_restart_over", over2, 0);
    start2 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
